// File: rtl/bj_pkg.sv
// Shared encodings for the branch/jump controller:
// BJ_CTRL classes and the FUNC3 branch conditions.
package bj_pkg;

  localparam logic [1:0] BJ_NONE   = 2'b00;
  localparam logic [1:0] BJ_BRANCH = 2'b01;
  localparam logic [1:0] BJ_JAL    = 2'b10;
  localparam logic [1:0] BJ_JALR   = 2'b11;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_cond_eval.sv
// Branch condition decode: picks the ALU flag
// named by FUNC3 and applies its polarity.
module branch_cond_eval
  import bj_pkg::*;
(
  input  logic [2:0] FUNC3,
  input  logic       ZERO,
  input  logic       SIGN_BIT,
  input  logic       SLTU_BIT,
  output logic       cond_true
);

  // 010/011 are not branch encodings
  always_comb begin
    cond_true = 1'b0;
    case (FUNC3)
      F3_BEQ:  cond_true = ZERO;
      F3_BNE:  cond_true = !ZERO;
      F3_BLT:  cond_true = SIGN_BIT;
      F3_BGE:  cond_true = !SIGN_BIT;
      F3_BLTU: cond_true = SLTU_BIT;
      F3_BGEU: cond_true = !SLTU_BIT;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/bj_controller.sv
// Branch/jump controller: target adder, redirect
// decision, and registered flush/target copies.
module bj_controller
  import bj_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] IMM,
  input  logic [1:0]      BJ_CTRL,
  input  logic [2:0]      FUNC3,
  input  logic            ZERO,
  input  logic            SIGN_BIT,
  input  logic            SLTU_BIT,
  output logic [XLEN-1:0] B_PC,
  output logic            BRANCH_SEL,
  output logic            FLUSH,
  output logic [XLEN-1:0] TARGET_Q
);

  logic            w_cond;
  logic            w_sel;
  logic [XLEN-1:0] w_target;
  logic            r_flush;
  logic [XLEN-1:0] r_target;

  branch_cond_eval u_cond (
    .FUNC3     (FUNC3),
    .ZERO      (ZERO),
    .SIGN_BIT  (SIGN_BIT),
    .SLTU_BIT  (SLTU_BIT),
    .cond_true (w_cond)
  );

  // carry-out is dropped: target wraps
  assign w_target = PC + IMM;

  always_comb begin
    w_sel = 1'b0;
    case (BJ_CTRL)
      BJ_NONE:   w_sel = 1'b0;
      BJ_BRANCH: w_sel = w_cond;
      BJ_JAL:    w_sel = 1'b1;
      BJ_JALR:   w_sel = 1'b1;
      default:   w_sel = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_flush  <= 1'b0;
      r_target <= '0;
    end else begin
      r_flush <= w_sel;
      if (w_sel)
        r_target <= w_target;
    end
  end

  assign B_PC       = w_target;
  assign BRANCH_SEL = w_sel;
  assign FLUSH      = r_flush;
  assign TARGET_Q   = r_target;

endmodule

// File: tb/tb_bj_controller.sv
// Directed bench for bj_controller: decode table,
// wrap-around target, register hold and async reset.
module tb_bj_controller;

  logic        CLK;
  logic        RESET;
  logic [31:0] PC;
  logic [31:0] IMM;
  logic [1:0]  BJ_CTRL;
  logic [2:0]  FUNC3;
  logic        ZERO;
  logic        SIGN_BIT;
  logic        SLTU_BIT;
  logic [31:0] B_PC;
  logic        BRANCH_SEL;
  logic        FLUSH;
  logic [31:0] TARGET_Q;

  int checks;
  int failures;

  bj_controller #(.XLEN(32)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .PC         (PC),
    .IMM        (IMM),
    .BJ_CTRL    (BJ_CTRL),
    .FUNC3      (FUNC3),
    .ZERO       (ZERO),
    .SIGN_BIT   (SIGN_BIT),
    .SLTU_BIT   (SLTU_BIT),
    .B_PC       (B_PC),
    .BRANCH_SEL (BRANCH_SEL),
    .FLUSH      (FLUSH),
    .TARGET_Q   (TARGET_Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h",
               tag, got, exp);
    end
  endtask

  task automatic drv(
    input logic [31:0] pc,
    input logic [31:0] imm,
    input logic [1:0]  ctl,
    input logic [2:0]  f3,
    input logic        z,
    input logic        s,
    input logic        u
  );
    @(negedge CLK);
    PC = pc;
    IMM = imm;
    BJ_CTRL = ctl;
    FUNC3 = f3;
    ZERO = z;
    SIGN_BIT = s;
    SLTU_BIT = u;
    #1;
  endtask

  task automatic sel(
    input string tag,
    input logic  exp
  );
    chk(tag, {31'd0, BRANCH_SEL}, {31'd0, exp});
  endtask

  initial begin
    checks = 0;
    failures = 0;
    RESET = 1'b1;
    PC = '0;
    IMM = '0;
    BJ_CTRL = 2'b00;
    FUNC3 = 3'b000;
    ZERO = 1'b0;
    SIGN_BIT = 1'b0;
    SLTU_BIT = 1'b0;
    #1;
    chk("rst_flush", {31'd0, FLUSH}, 32'd0);
    chk("rst_tgt", TARGET_Q, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;

    drv(0, 4, 2'b00, 3'b000, 1, 0, 0);
    chk("none_bpc", B_PC, 32'h4);
    sel("none_beq", 1'b0);

    drv(0, 8, 2'b00, 3'b001, 0, 0, 0);
    chk("none_bpc8", B_PC, 32'h8);
    sel("none_bne", 1'b0);
    drv(0, 8, 2'b01, 3'b001, 0, 0, 0);
    sel("bne_taken", 1'b1);

    drv(16, 32'hFFFF_FFF0, 2'b01, 3'b000, 1, 0, 0);
    chk("neg_imm", B_PC, 32'h0);
    sel("beq_taken", 1'b1);
    drv(16, 4, 2'b01, 3'b000, 0, 0, 0);
    sel("beq_not", 1'b0);
    drv(16, 4, 2'b01, 3'b100, 0, 1, 0);
    sel("blt_taken", 1'b1);

    drv(0, 4, 2'b01, 3'b101, 0, 0, 0);
    sel("bge_taken", 1'b1);
    drv(0, 4, 2'b01, 3'b101, 0, 1, 0);
    sel("bge_not", 1'b0);

    drv(0, 4, 2'b01, 3'b110, 1, 0, 1);
    sel("bltu_taken", 1'b1);
    drv(0, 4, 2'b01, 3'b111, 1, 0, 1);
    sel("bgeu_not", 1'b0);
    drv(0, 4, 2'b01, 3'b000, 1, 0, 1);
    sel("beq_zsltu", 1'b1);
    drv(0, 4, 2'b01, 3'b001, 1, 0, 1);
    sel("bne_zsltu", 1'b0);
    drv(0, 4, 2'b01, 3'b010, 1, 1, 1);
    sel("f3_010", 1'b0);
    drv(0, 4, 2'b01, 3'b011, 1, 1, 1);
    sel("f3_011", 1'b0);
    drv(0, 4, 2'b00, 3'b110, 1, 1, 1);
    sel("none_allset", 1'b0);
    drv(0, 4, 2'b11, 3'b001, 1, 0, 0);
    sel("jalr", 1'b1);

    drv(32'hFFFF_FFFC, 8, 2'b10, 3'b000, 0, 0, 0);
    chk("wrap_bpc", B_PC, 32'h4);
    sel("wrap_jal", 1'b1);
    @(posedge CLK);
    #1;
    chk("wrap_flush", {31'd0, FLUSH}, 32'd1);
    chk("wrap_tgt", TARGET_Q, 32'h4);

    drv(32'h100, 32'h10, 2'b00, 3'b000, 1, 0, 0);
    @(posedge CLK);
    #1;
    chk("hold_flush", {31'd0, FLUSH}, 32'd0);
    chk("hold_tgt", TARGET_Q, 32'h4);

    drv(32'h1000, 32'h20, 2'b10, 3'b000, 0, 0, 0);
    @(posedge CLK);
    #1;
    chk("jal_flush", {31'd0, FLUSH}, 32'd1);
    chk("jal_tgt", TARGET_Q, 32'h1020);

    #1;
    RESET = 1'b1;
    #1;
    chk("mid_rst_flush", {31'd0, FLUSH}, 32'd0);
    chk("mid_rst_tgt", TARGET_Q, 32'd0);
    chk("mid_rst_bpc", B_PC, 32'h1020);
    sel("mid_rst_sel", 1'b1);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    chk("post_rst_flush", {31'd0, FLUSH}, 32'd1);
    chk("post_rst_tgt", TARGET_Q, 32'h1020);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
